// File: rtl/rrd_pkg.sv
// Shared definitions for the rrd (register read / dispatch) stage.
//   - Default widths for register index, data word and ROB tag.
//   - Default port counts for the tagged register file.
//   - Convenience typedefs sized from the defaults.
package rrd_pkg;

  localparam int unsigned S_INDEX          = 5;
  localparam int unsigned S_WIDTH          = 32;
  localparam int unsigned S_TAG            = 4;
  localparam int unsigned NUM_READ_PORTS   = 2;
  localparam int unsigned NUM_WRITE_PORTS  = 3;
  localparam int unsigned NUM_RENAME_PORTS = 1;

  typedef logic [S_INDEX-1:0] reg_idx_t;
  typedef logic [S_WIDTH-1:0] reg_data_t;
  typedef logic [S_TAG-1:0]   rob_tag_t;

endpackage

// File: rtl/regfile_status.sv
// Busy/tag status array for the tagged register file.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : clear every busy bit, drop same-cycle renames
//   ld/dest/cmt_tag : commit ports; clear busy when the committing tag
//                   still owns the register
//   rn_valid/rn_dest/rn_tag : rename ports; mark busy and record tag
//   src           : read indices
//   out_busy/out_tag : per-read status, with same-cycle commit clearing
//                   folded in (renames are not visible this cycle)
module regfile_status
  import rrd_pkg::*;
#(
  parameter int unsigned s_index          = S_INDEX,
  parameter int unsigned s_tag            = S_TAG,
  parameter int unsigned num_read_ports   = NUM_READ_PORTS,
  parameter int unsigned num_write_ports  = NUM_WRITE_PORTS,
  parameter int unsigned num_rename_ports = NUM_RENAME_PORTS
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic [num_write_ports-1:0]                   ld,
  input  logic [num_write_ports-1:0][s_index-1:0]      dest,
  input  logic [num_write_ports-1:0][s_tag-1:0]        cmt_tag,
  input  logic [num_rename_ports-1:0]                  rn_valid,
  input  logic [num_rename_ports-1:0][s_index-1:0]     rn_dest,
  input  logic [num_rename_ports-1:0][s_tag-1:0]       rn_tag,
  input  logic [num_read_ports-1:0][s_index-1:0]       src,
  output logic [num_read_ports-1:0]                    out_busy,
  output logic [num_read_ports-1:0][s_tag-1:0]         out_tag
);

  localparam int unsigned num_regs = 2 ** s_index;

  logic [num_regs-1:0] busy_q, busy_d;
  logic [s_tag-1:0]    tag_q [num_regs];
  logic [s_tag-1:0]    tag_d [num_regs];

  // Next-state priority (lowest to highest): commit clear, rename, flush.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < num_regs; r++) begin
      tag_d[r] = tag_q[r];
    end

    // Clear decisions look only at the pre-edge state, so the order of
    // commit ports is irrelevant here.
    for (int unsigned i = 0; i < num_write_ports; i++) begin
      if (ld[i] && (dest[i] != '0) && busy_q[dest[i]] &&
          (tag_q[dest[i]] == cmt_tag[i])) begin
        busy_d[dest[i]] = 1'b0;
      end
    end

    if (!flush) begin
      for (int unsigned j = 0; j < num_rename_ports; j++) begin
        if (rn_valid[j] && (rn_dest[j] != '0)) begin
          busy_d[rn_dest[j]] = 1'b1;
          tag_d[rn_dest[j]]  = rn_tag[j];
        end
      end
    end else begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned r = 0; r < num_regs; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int unsigned r = 0; r < num_regs; r++) begin
        tag_q[r] <= tag_d[r];
      end
    end
  end

  // A read sees a pending source as ready when its producer commits this
  // cycle; register 0 is never marked busy so it reads back all zeros.
  always_comb begin
    for (int unsigned p = 0; p < num_read_ports; p++) begin
      out_busy[p] = busy_q[src[p]];
      for (int unsigned i = 0; i < num_write_ports; i++) begin
        if (ld[i] && (dest[i] == src[p]) && (cmt_tag[i] == tag_q[src[p]])) begin
          out_busy[p] = 1'b0;
        end
      end
      if (src[p] == '0) begin
        out_busy[p] = 1'b0;
      end
      out_tag[p] = out_busy[p] ? tag_q[src[p]] : '0;
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy/tag status.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : clear all busy bits (commit data still written)
//   ld/dest/in/cmt_tag : commit ports from the ROB head
//   rn_valid/rn_dest/rn_tag : rename ports from dispatch
//   src        : read indices
//   out        : read data with same-cycle commit bypass
//   out_busy   : source still pending
//   out_tag    : producing ROB tag when busy, else 0
module regfile_tagged
  import rrd_pkg::*;
#(
  parameter int unsigned s_index          = S_INDEX,
  parameter int unsigned s_width          = S_WIDTH,
  parameter int unsigned s_tag            = S_TAG,
  parameter int unsigned num_read_ports   = NUM_READ_PORTS,
  parameter int unsigned num_write_ports  = NUM_WRITE_PORTS,
  parameter int unsigned num_rename_ports = NUM_RENAME_PORTS
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic [num_write_ports-1:0]                   ld,
  input  logic [num_write_ports-1:0][s_index-1:0]      dest,
  input  logic [num_write_ports-1:0][s_width-1:0]      in,
  input  logic [num_write_ports-1:0][s_tag-1:0]        cmt_tag,
  input  logic [num_rename_ports-1:0]                  rn_valid,
  input  logic [num_rename_ports-1:0][s_index-1:0]     rn_dest,
  input  logic [num_rename_ports-1:0][s_tag-1:0]       rn_tag,
  input  logic [num_read_ports-1:0][s_index-1:0]       src,
  output logic [num_read_ports-1:0][s_width-1:0]       out,
  output logic [num_read_ports-1:0]                    out_busy,
  output logic [num_read_ports-1:0][s_tag-1:0]         out_tag
);

  localparam int unsigned num_regs = 2 ** s_index;

  logic [s_width-1:0] data_q [num_regs];
  logic [s_width-1:0] data_d [num_regs];

  regfile_status #(
    .s_index          (s_index),
    .s_tag            (s_tag),
    .num_read_ports   (num_read_ports),
    .num_write_ports  (num_write_ports),
    .num_rename_ports (num_rename_ports)
  ) u_status (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .ld       (ld),
    .dest     (dest),
    .cmt_tag  (cmt_tag),
    .rn_valid (rn_valid),
    .rn_dest  (rn_dest),
    .rn_tag   (rn_tag),
    .src      (src),
    .out_busy (out_busy),
    .out_tag  (out_tag)
  );

  // Ascending port order makes the highest-index commit win on collisions.
  always_comb begin
    for (int unsigned r = 0; r < num_regs; r++) begin
      data_d[r] = data_q[r];
    end
    for (int unsigned i = 0; i < num_write_ports; i++) begin
      if (ld[i] && (dest[i] != '0)) begin
        data_d[dest[i]] = in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < num_regs; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < num_regs; r++) begin
        data_q[r] <= data_d[r];
      end
    end
  end

  // Commit-to-read bypass, same priority as the write path.
  always_comb begin
    for (int unsigned p = 0; p < num_read_ports; p++) begin
      out[p] = data_q[src[p]];
      for (int unsigned i = 0; i < num_write_ports; i++) begin
        if (ld[i] && (dest[i] == src[p])) begin
          out[p] = in[i];
        end
      end
      if (src[p] == '0) begin
        out[p] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_tagged.sv
module tb_regfile_tagged;

  localparam int NRP = 2;
  localparam int NWP = 3;
  localparam int NRN = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [NWP-1:0]          ld;
  logic [NWP-1:0][4:0]     dest;
  logic [NWP-1:0][31:0]    wdata;
  logic [NWP-1:0][3:0]     cmt_tag;
  logic [NRN-1:0]          rn_valid;
  logic [NRN-1:0][4:0]     rn_dest;
  logic [NRN-1:0][3:0]     rn_tag;
  logic [NRP-1:0][4:0]     src;
  logic [NRP-1:0][31:0]    out;
  logic [NRP-1:0]          out_busy;
  logic [NRP-1:0][3:0]     out_tag;

  regfile_tagged #(
    .s_index          (5),
    .s_width          (32),
    .s_tag            (4),
    .num_read_ports   (NRP),
    .num_write_ports  (NWP),
    .num_rename_ports (NRN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .ld       (ld),
    .dest     (dest),
    .in       (wdata),
    .cmt_tag  (cmt_tag),
    .rn_valid (rn_valid),
    .rn_dest  (rn_dest),
    .rn_tag   (rn_tag),
    .src      (src),
    .out      (out),
    .out_busy (out_busy),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRP-1:0][31:0] out;
    logic [NRP-1:0]       busy;
    logic [NRP-1:0][3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural value, pending flag and owner tag per register.
  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0;
      m_busy[r] = 0;
      m_tag[r]  = '0;
    end
  endfunction

  // Reads observe the register state before this edge, with committing
  // instructions already counted as done.
  function automatic exp_t model_read();
    exp_t e;
    for (int p = 0; p < NRP; p++) begin
      int s;
      bit b;
      logic [31:0] v;
      s = int'(src[p]);
      v = m_data[s];
      b = m_busy[s];
      for (int i = 0; i < NWP; i++) begin
        if (ld[i] && int'(dest[i]) == s) begin
          v = wdata[i];
          if (cmt_tag[i] == m_tag[s]) b = 0;
        end
      end
      if (s == 0) begin
        v = '0;
        b = 0;
      end
      e.out[p]  = v;
      e.busy[p] = b;
      e.tag[p]  = b ? m_tag[s] : 4'd0;
    end
    return e;
  endfunction

  function automatic void model_edge();
    logic [31:0] nd [32];
    bit          nb [32];
    logic [3:0]  nt [32];
    if (rst) begin
      model_clear();
      return;
    end
    for (int r = 0; r < 32; r++) begin
      nd[r] = m_data[r];
      nb[r] = m_busy[r];
      nt[r] = m_tag[r];
    end
    for (int i = 0; i < NWP; i++) begin
      int d;
      d = int'(dest[i]);
      if (ld[i] && d != 0) begin
        nd[d] = wdata[i];
        if (m_busy[d] && m_tag[d] == cmt_tag[i]) nb[d] = 0;
      end
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) nb[r] = 0;
    end else begin
      for (int j = 0; j < NRN; j++) begin
        if (rn_valid[j] && rn_dest[j] != 5'd0) begin
          nb[int'(rn_dest[j])] = 1;
          nt[int'(rn_dest[j])] = rn_tag[j];
        end
      end
    end
    for (int r = 0; r < 32; r++) begin
      m_data[r] = nd[r];
      m_busy[r] = nb[r];
      m_tag[r]  = nt[r];
    end
  endfunction

  task automatic clr();
    rst = 0; flush = 0; ld = '0; dest = '0; wdata = '0; cmt_tag = '0;
    rn_valid = '0; rn_dest = '0; rn_tag = '0; src = '0;
  endtask

  // Inputs are already driven; record expectation, cross the edge, advance model.
  task automatic step();
    sb.push_back(model_read());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmt(input int port, input int d, input logic [31:0] v, input logic [3:0] t);
    ld[port] = 1'b1;
    dest[port] = 5'(d);
    wdata[port] = v;
    cmt_tag[port] = t;
  endtask

  task automatic ren(input int port, input int d, input logic [3:0] t);
    rn_valid[port] = 1'b1;
    rn_dest[port] = 5'(d);
    rn_tag[port] = t;
  endtask

  task automatic rd(input int a, input int b);
    src[0] = 5'(a);
    src[1] = 5'(b);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      for (int p = 0; p < NRP; p++) begin
        checks++;
        if (out[p] !== e.out[p]) begin
          errors++;
          $display("FAIL out[%0d] src=%0d got %h exp %h @%0t", p, src[p], out[p], e.out[p], $time);
        end
        checks++;
        if (out_busy[p] !== e.busy[p]) begin
          errors++;
          $display("FAIL out_busy[%0d] src=%0d got %b exp %b @%0t", p, src[p], out_busy[p], e.busy[p], $time);
        end
        checks++;
        if (out_tag[p] !== e.tag[p]) begin
          errors++;
          $display("FAIL out_tag[%0d] src=%0d got %h exp %h @%0t", p, src[p], out_tag[p], e.tag[p], $time);
        end
      end
    end
  end

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    model_clear();
    #1;
    clr();

    // Reset state and register 0.
    rd(0, 5); step();
    rd(1, 31); step();
    clr(); cmt(0, 0, 32'hFFFF_FFFF, 4'd0); rd(0, 0); step();
    clr(); rd(0, 0); step();

    // Rename then commit with bypass.
    clr(); ren(0, 5, 4'd3); rd(5, 0); step();
    clr(); rd(5, 5); step();
    clr(); cmt(1, 5, 32'h1234, 4'd3); rd(5, 0); step();
    clr(); rd(5, 5); step();

    // Stale tag commit does not clear newer rename.
    clr(); ren(0, 7, 4'd2); step();
    clr(); ren(0, 7, 4'd6); step();
    clr(); cmt(0, 7, 32'hAA, 4'd2); rd(7, 7); step();
    clr(); rd(7, 0); step();

    // Port priority on collisions.
    clr(); cmt(0, 9, 32'h11, 4'd0); cmt(2, 9, 32'h22, 4'd0); rd(9, 9); step();
    clr(); rd(9, 9); step();
    clr(); ren(0, 9, 4'd4); ren(1, 9, 4'd5); step();
    clr(); rd(9, 0); step();

    // Rename beats clear on the same register.
    clr(); ren(0, 4, 4'd1); step();
    clr(); ren(0, 4, 4'd5); cmt(0, 4, 32'h77, 4'd1); rd(4, 4); step();
    clr(); rd(4, 0); step();

    // Flush drops renames and clears busy; commit data still lands.
    clr(); ren(0, 3, 4'd7); ren(1, 8, 4'd8); step();
    clr(); rd(3, 8); step();
    clr(); flush = 1; ren(0, 10, 4'd1); cmt(0, 3, 32'h9, 4'd0); rd(3, 10); step();
    clr(); rd(3, 10); step();
    clr(); rd(8, 4); step();

    // Reset mid-sequence with competing activity.
    clr(); rst = 1; ren(0, 12, 4'd9); cmt(2, 9, 32'h55, 4'd0); rd(9, 7); step();
    clr(); rd(9, 7); step();
    clr(); rd(4, 3); step();

    // Randomised traffic over a narrow register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      clr();
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NWP; i++) begin
        ld[i]    = $urandom_range(0, 1);
        dest[i]  = 5'($urandom_range(0, 11));
        wdata[i] = $urandom;
        cmt_tag[i] = ($urandom_range(0, 2) != 0) ? m_tag[int'(dest[i])] : 4'($urandom_range(0, 15));
      end
      for (int j = 0; j < NRN; j++) begin
        rn_valid[j] = $urandom_range(0, 1);
        rn_dest[j]  = 5'($urandom_range(0, 11));
        rn_tag[j]   = 4'($urandom_range(0, 15));
      end
      for (int p = 0; p < NRP; p++) begin
        src[p] = ($urandom_range(0, 3) == 0) ? dest[$urandom_range(0, NWP-1)] : 5'($urandom_range(0, 11));
      end
      step();
    end

    clr();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_tagged.md
Name: regfile_tagged

Overview:
- Architectural register file with per-register busy/tag status for ROB-based dispatch. Generalises the plain multi-port regfile with parametrised rename ports, tag-qualified busy clearing, and same-cycle commit-to-read bypass.
- Sits in the rrd stage: rename ports are driven by dispatch, commit ports by the ROB head, and read ports feed the reservation stations.

Parameters:
- s_index, 5, register index width; num_regs = 2**s_index.
- s_width, 32, data width.
- s_tag, 4, ROB tag width.
- num_read_ports (nrp), 2, read ports.
- num_write_ports (nwp), 3, commit/write ports.
- num_rename_ports (nrn), 1, rename (tag allocate) ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  clear all busy bits (mispredict/exception).
- ld  in  [nwp]  commit write valid per port.
- dest  in  [s_index] x nwp  commit destination register.
- in  in  [s_width] x nwp  commit data.
- cmt_tag  in  [s_tag] x nwp  ROB tag of committing instruction.
- rn_valid  in  [nrn]  rename valid per port.
- rn_dest  in  [s_index] x nrn  renamed destination register.
- rn_tag  in  [s_tag] x nrn  newly allocated ROB tag.
- src  in  [s_index] x nrp  read index.
- out  out  [s_width] x nrp  read data.
- out_busy  out  [nrp]  source still pending.
- out_tag  out  [s_tag] x nrp  producing tag when busy.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On rst, all data, busy and tag entries go to 0. rst overrides flush, commit and rename in the same cycle.
- Register 0: reads always return out=0, out_busy=0, out_tag=0. Commits and renames targeting 0 are ignored.
- Commit (posedge, ld[i] && dest[i]!=0):
  - data[dest[i]] <= in[i].
  - busy[dest[i]] clears only if tag[dest[i]]==cmt_tag[i] and busy is set.
  - Multiple commit ports to the same dest: highest index wins for data.
- Rename (posedge, rn_valid[j] && rn_dest[j]!=0): busy[rn_dest[j]] <= 1 and tag <= rn_tag[j].
  - Multiple rename ports to the same dest: highest index wins.
- Rename vs commit on the same register in the same cycle: data is written; busy stays 1 and the tag takes the rename value (rename beats clear).
- flush: next cycle all busy=0; tags are don't-care. flush beats rename, and rename is dropped. Commit data writes in the flush cycle still complete.
- Reads are combinational, zero latency, and reflect pre-rename state:
  - out = data of the highest-index commit port with ld && dest==src, else data[src].
  - out_busy = busy[src] && !(some commit port matches src with cmt_tag==tag[src]).
  - out_tag = tag[src] when out_busy, else 0.
  - Same-cycle renames are not visible to same-cycle reads.
- No stalls, no handshake; all ports are accepted every cycle.

Decomposition:
- Shared package rrd_pkg: s_index/s_width/s_tag defaults, and typedefs reg_idx_t, reg_data_t, rob_tag_t.
- One sub-module, regfile_status, holds busy/tag arrays, rename/commit/flush priority and busy-read logic. The top level holds the data array and the bypass muxing.

Test Plan:
- Reset, then read src={0,5} -> out={0,0}, out_busy={0,0}; commit dest=0 in=0xFFFF_FFFF, then read 0 -> 0.
- Rename r5 tag=3; next cycle read r5 -> busy=1, tag=3. Commit r5 tag=3 in=0x1234 and read r5 in the same cycle -> out=0x1234, busy=0. Next cycle -> data 0x1234, busy 0.
- Rename r7 tag=2, then rename r7 tag=6, then commit r7 tag=2 in=0xAA -> data=0xAA, busy=1, tag=6.
- Commit ports 0 and 2 both to r9 (0x11, 0x22) -> r9=0x22. Rename ports 0 and 1 both to r9 (nrn=2) -> tag = port-1 value.
- Same cycle: rename r4 tag=5 and commit r4 (tag matching old) in=0x77 -> next cycle data=0x77, busy=1, tag=5.
- Rename r3 and r8, then flush together with rename r10 tag=1 and commit r3 in=0x9 -> all busy=0, r3=0x9, r10 not busy. Assert rst mid-sequence -> all entries 0 next cycle.
